led_pattern_ctrl: RTL and testbench
===================================

Name: led_pattern_ctrl

Overview:
- Sequencer that drives the four board LEDs on the MachXO3D platform from the internal-oscillator clock.
- Replaces the raw free-running counter MSB taps with selectable patterns.
- A debounced push-button steps a mode state machine through four patterns.
- A programmable prescaler sets the pattern update rate.

Parameters:
- TICK_DIV, 13300000, clk1 cycles per pattern update (about 4 Hz at 53.20 MHz); must be >= 2.
- DEB_CYCLES, 532000, consecutive clk1 cycles a changed button level must hold before it is accepted (about 10 ms); must be >= 2.

Ports:
- clk1  input  1  platform clock from the internal oscillator (53.20 MHz nominal).
- rstn  input  1  reset.
- btn_n  input  1  raw push-button, active-low, asynchronous to clk1, bouncy.
- led  output  4  LED pattern, bit 0 = LEDPIO_OUT0; driven from a register.
- mode  output  2  current mode: 0 BIN, 1 WALK, 2 PING, 3 BLINK.
- tick  output  1  one-cycle pulse on each pattern update slot (debug/scope).

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk1.
- Values while rstn is low, taking effect immediately:
  - led=0000, mode=0 (BIN), tick=0, dir=up.
  - Prescaler and debounce counters = 0.
  - Both synchroniser flops = 1; debounced level stable = 1; press = 0.
- Synchroniser: 2 flops on btn_n; only the second flop (s2) is used.
- Debounce:
  - If s2 == stable, the counter clears.
  - Otherwise the counter increments each cycle.
  - When the counter == DEB_CYCLES-1 while s2 != stable: stable <= s2 and the counter clears.
- Press detection:
  - press is a registered one-cycle pulse, set the cycle after stable goes from 1 to 0.
  - Releasing the button never generates a press. Holding it generates exactly one press.
- Press latency: the mode update occurs on the (DEB_CYCLES+4)th rising edge, counting the edge that first samples btn_n low as edge 1.
- Glitch rule: a low pulse shorter than DEB_CYCLES cycles at s2 produces no press.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick is registered high for the one cycle following the count reaching TICK_DIV-1.
  - The pattern updates in the same cycle tick is high.
- Mode FSM:
  - Transitions: BIN -> WALK -> PING -> BLINK -> BIN; it advances only on press.
  - On press: load the entry pattern, clear the prescaler, and set dir=up.
  - Entry patterns: BIN 0000, WALK 0001, PING 0001, BLINK 0000.
- Pattern update on tick, when no press is present:
  - BIN: led <= led+1, modulo 16 (1111 -> 0000).
  - WALK: rotate left (1000 -> 0001).
  - PING, dir up: 1000 -> 0100 and set dir=down; otherwise shift left.
  - PING, dir down: 0001 -> 0010 and set dir=up; otherwise shift right.
  - BLINK: led <= ~led.
- Simultaneous press and tick: press wins; the tick is discarded and the new mode's entry pattern is loaded.
- Reset asserted mid-operation: all state returns to reset values immediately; a pending press is lost.
- Widths: prescaler is $clog2(TICK_DIV) bits; debounce counter is $clog2(DEB_CYCLES) bits; no other arithmetic overflow is possible.

Decomposition:
- Shared package led_ctrl_pkg holds:
  - mode enum: MODE_BIN=2'd0, MODE_WALK=2'd1, MODE_PING=2'd2, MODE_BLINK=2'd3.
  - Entry-pattern constants.
  - Default TICK_DIV and DEB_CYCLES for the 53.20 MHz oscillator.
- One sub-module, btn_debounce (synchroniser, debounce counter, press pulse; parameter DEB_CYCLES), reusable for other board buttons.
- The prescaler, mode FSM and pattern register stay in led_pattern_ctrl.

Test Plan (TICK_DIV=4, DEB_CYCLES=3):
- Reset, button idle -> led=0000, mode=0; tick every 4 cycles; led steps 0001..1111 and wraps to 0000 on the 16th tick.
- btn_n low for 2 cycles, then high -> no press; mode stays 0 and the BIN count continues uninterrupted.
- btn_n held low for 30 cycles -> exactly one mode change to 1 on edge 7; led=0001, then 0010, 0100, 1000, 0001 on successive ticks; release produces no change.
- Second press -> mode=2; led sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
- Third press -> mode=3; led 0000, 1111, 0000. Fourth press -> mode=0, led=0000. Also force a press in the same cycle as tick -> entry pattern loaded and the tick ignored.
- rstn pulsed low mid-PING (led=0100, dir=down) -> led=0000, mode=0, tick=0 asynchronously; after release, BIN counting resumes from 0000 with the first tick 4 cycles later.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED pattern sequencer: mode encoding,
// per-mode entry patterns and the prescaler/debounce defaults for the 53.20 MHz oscillator.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_BIN   = 2'd0,
        MODE_WALK  = 2'd1,
        MODE_PING  = 2'd2,
        MODE_BLINK = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [3:0] ENTRY_BIN   = 4'b0000;
    localparam logic [3:0] ENTRY_WALK  = 4'b0001;
    localparam logic [3:0] ENTRY_PING  = 4'b0001;
    localparam logic [3:0] ENTRY_BLINK = 4'b0000;

    // ~4 Hz pattern rate and ~10 ms debounce at 53.20 MHz
    localparam int TICK_DIV_DEFAULT   = 13300000;
    localparam int DEB_CYCLES_DEFAULT = 532000;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_BIN:  return MODE_WALK;
            MODE_WALK: return MODE_PING;
            MODE_PING: return MODE_BLINK;
            default:   return MODE_BIN;
        endcase
    endfunction

    function automatic logic [3:0] entry_pattern(input mode_t m);
        case (m)
            MODE_BIN:  return ENTRY_BIN;
            MODE_WALK: return ENTRY_WALK;
            MODE_PING: return ENTRY_PING;
            default:   return ENTRY_BLINK;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, level debounce, one-cycle press pulse on 1->0.
// press is high DEB_CYCLES+3 edges after the first edge that samples btn_n low; no backpressure.
module btn_debounce
    import led_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk1,
    input  logic rstn,
    input  logic btn_n,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            s1       <= 1'b1;
            s2       <= 1'b1;
            stable   <= 1'b1;
            stable_d <= 1'b1;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            s1       <= btn_n;
            s2       <= s1;
            stable_d <= stable;
            // only a falling debounced level is a press; releases are ignored
            press    <= stable_d & ~stable;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Four-LED pattern sequencer: prescaled update slots, button-stepped mode FSM, registered LED outputs.
// led/tick change on the same edge (one slot every TICK_DIV cycles); a press reloads and restarts the slot.
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_DEFAULT,
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic       clk1,
    input  logic       rstn,
    input  logic       btn_n,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic       tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PC_LAST = PW'(TICK_DIV - 1);

    logic          press;
    mode_t         state_q, state_d;
    dir_t          dir_q, dir_d;
    logic [3:0]    led_q, led_d;
    logic [PW-1:0] pc_q, pc_d;
    logic          tick_q, tick_d;
    logic          tick_en;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_btn (
        .clk1  (clk1),
        .rstn  (rstn),
        .btn_n (btn_n),
        .press (press)
    );

    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            state_q <= MODE_BIN;
            dir_q   <= DIR_UP;
            led_q   <= 4'b0000;
            pc_q    <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            led_q   <= led_d;
            pc_q    <= pc_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        tick_en = (pc_q == PC_LAST);
        state_d = state_q;
        dir_d   = dir_q;
        led_d   = led_q;
        pc_d    = tick_en ? '0 : pc_q + 1'b1;
        tick_d  = tick_en;
        if (press) begin
            // a press swallows any coincident slot and restarts slot timing
            state_d = next_mode(state_q);
            led_d   = entry_pattern(state_d);
            dir_d   = DIR_UP;
            pc_d    = '0;
            tick_d  = 1'b0;
        end else if (tick_en) begin
            case (state_q)
                MODE_BIN:  led_d = led_q + 4'd1;
                MODE_WALK: led_d = {led_q[2:0], led_q[3]};
                MODE_PING: begin
                    if (dir_q == DIR_UP) begin
                        if (led_q == 4'b1000) begin
                            led_d = 4'b0100;
                            dir_d = DIR_DOWN;
                        end else begin
                            led_d = led_q << 1;
                        end
                    end else begin
                        if (led_q == 4'b0001) begin
                            led_d = 4'b0010;
                            dir_d = DIR_UP;
                        end else begin
                            led_d = led_q >> 1;
                        end
                    end
                end
                default:   led_d = ~led_q;
            endcase
        end
    end

    assign led  = led_q;
    assign mode = state_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl with TICK_DIV=4, DEB_CYCLES=3: per-cycle scoreboard plus directed sequences.
module tb_led_pattern_ctrl;

    localparam int TD  = 4;
    localparam int DEB = 3;

    logic       clk1  = 1'b0;
    logic       rstn  = 1'b0;
    logic       btn_n = 1'b1;
    logic [3:0] led;
    logic [1:0] mode;
    logic       tick;

    led_pattern_ctrl #(
        .TICK_DIV   (TD),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk1  (clk1),
        .rstn  (rstn),
        .btn_n (btn_n),
        .led   (led),
        .mode  (mode),
        .tick  (tick)
    );

    always #5 clk1 = ~clk1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model of the button path, prescaler and pattern FSM
    logic       m_s1, m_s2, m_stable, m_stable_d, m_press, m_tick, m_dir;
    int         m_cnt, m_pc;
    logic [3:0] m_led;
    logic [1:0] m_mode;

    function automatic logic [3:0] entry(input logic [1:0] md);
        case (md)
            2'd1, 2'd2: return 4'b0001;
            default:    return 4'b0000;
        endcase
    endfunction

    task automatic model_reset();
        m_s1 = 1'b1; m_s2 = 1'b1; m_stable = 1'b1; m_stable_d = 1'b1;
        m_press = 1'b0; m_tick = 1'b0; m_dir = 1'b0;
        m_cnt = 0; m_pc = 0; m_led = 4'b0000; m_mode = 2'd0;
    endtask

    task automatic model_edge(input logic b);
        logic n_st, n_pr, n_tk, n_dir, tk;
        int n_cnt, n_pc;
        logic [3:0] n_led;
        logic [1:0] n_mode;
        n_st  = m_stable;
        n_cnt = 0;
        if (m_s2 !== m_stable) begin
            if (m_cnt == DEB - 1) n_st = m_s2;
            else n_cnt = m_cnt + 1;
        end
        n_pr   = m_stable_d & ~m_stable;
        tk     = (m_pc == TD - 1);
        n_mode = m_mode;
        n_led  = m_led;
        n_dir  = m_dir;
        n_pc   = tk ? 0 : m_pc + 1;
        n_tk   = tk;
        if (m_press) begin
            n_mode = m_mode + 2'd1;
            n_led  = entry(n_mode);
            n_pc   = 0;
            n_dir  = 1'b0;
            n_tk   = 1'b0;
        end else if (tk) begin
            case (m_mode)
                2'd0: n_led = m_led + 4'd1;
                2'd1: n_led = {m_led[2:0], m_led[3]};
                2'd2: begin
                    if (!m_dir) begin
                        if (m_led == 4'b1000) begin n_led = 4'b0100; n_dir = 1'b1; end
                        else n_led = m_led << 1;
                    end else begin
                        if (m_led == 4'b0001) begin n_led = 4'b0010; n_dir = 1'b0; end
                        else n_led = m_led >> 1;
                    end
                end
                default: n_led = ~m_led;
            endcase
        end
        m_stable_d = m_stable;
        m_stable   = n_st;
        m_cnt      = n_cnt;
        m_s2       = m_s1;
        m_s1       = b;
        m_press    = n_pr;
        m_mode     = n_mode;
        m_led      = n_led;
        m_dir      = n_dir;
        m_pc       = n_pc;
        m_tick     = n_tk;
    endtask

    typedef struct packed {
        logic [3:0] led;
        logic [1:0] mode;
        logic       tick;
    } exp_t;

    exp_t sb[$];
    exp_t sb_e;

    always @(negedge clk1) begin
        if (sb.size() != 0) begin
            sb_e = sb.pop_front();
            check("scoreboard", 32'({led, mode, tick}), 32'(sb_e));
        end
    end

    // drive one cycle of btn_n, queue the model's post-edge outputs, return just after the edge
    task automatic step(input logic b);
        btn_n = b;
        model_edge(b);
        sb.push_back(exp_t'({m_led, m_mode, m_tick}));
        @(posedge clk1);
        #1;
    endtask

    task automatic wait_tick(input logic b, output int gap);
        gap = 0;
        do begin
            step(b);
            gap++;
        end while (tick !== 1'b1 && gap < 16);
        if (tick !== 1'b1) check("tick_timeout", 32'(tick), 32'd1);
    endtask

    task automatic do_press(input logic [1:0] exp_mode, input logic [3:0] exp_led);
        logic [1:0] old;
        int edges;
        old   = mode;
        edges = 0;
        do begin
            step(1'b0);
            edges++;
        end while (mode === old && edges < 20);
        check("press_edge", 32'(edges), 32'(DEB + 4));
        check("press_mode", 32'(mode), 32'(exp_mode));
        check("press_entry", 32'(led), 32'(exp_led));
        check("press_tick", 32'(tick), 32'd0);
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [3:0] entry_led;
        int         n;
        logic [3:0] seq[8];
    } press_vec_t;

    press_vec_t pt[4];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int gap;
        int nt;
        logic [3:0] prev;

        pt[0] = '{2'd1, 4'b0001, 4, '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000}};
        pt[1] = '{2'd2, 4'b0001, 7, '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0000}};
        pt[2] = '{2'd3, 4'b0000, 2, '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000}};
        pt[3] = '{2'd0, 4'b0000, 1, '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000}};

        model_reset();
        repeat (3) @(negedge clk1);
        check("reset_led", 32'(led), 32'd0);
        check("reset_mode", 32'(mode), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        #1 rstn = 1'b1;

        // BIN counts 0001..1111 then wraps to 0000 on the 16th slot
        for (int i = 0; i < 16; i++) begin
            wait_tick(1'b1, gap);
            check("bin_gap", 32'(gap), 32'(TD));
            check("bin_led", 32'(led), 32'((i + 1) % 16));
        end

        // short low glitch: no press, count carries on
        prev = led;
        nt   = 0;
        step(1'b0);
        if (tick === 1'b1) nt++;
        step(1'b0);
        if (tick === 1'b1) nt++;
        for (int i = 0; i < 20; i++) begin
            step(1'b1);
            if (tick === 1'b1) nt++;
        end
        check("glitch_mode", 32'(mode), 32'd0);
        check("glitch_count", 32'(led), 32'(4'(prev + 4'(nt))));

        // held presses step through every mode
        for (int p = 0; p < 4; p++) begin
            do_press(pt[p].mode, pt[p].entry_led);
            for (int i = 0; i < pt[p].n; i++) begin
                wait_tick(1'b0, gap);
                check("mode_gap", 32'(gap), 32'(TD));
                check("mode_led", 32'(led), 32'(pt[p].seq[i]));
            end
            repeat (8) step(1'b1);
            check("release_mode", 32'(mode), 32'(pt[p].mode));
        end

        // press lands in the same cycle as a slot: entry pattern wins, slot timing restarts
        for (int k = 0; k < 8 && m_pc != 1; k++) step(1'b1);
        do_press(2'd1, 4'b0001);
        wait_tick(1'b0, gap);
        check("coin_gap", 32'(gap), 32'(TD));
        check("coin_led", 32'(led), 32'(4'b0010));
        repeat (8) step(1'b1);

        // into PING, run to led=0100 heading down, then reset asynchronously
        do_press(2'd2, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            wait_tick(1'b0, gap);
            check("ping_led", 32'(led), 32'(pt[1].seq[i]));
        end
        @(negedge clk1);
        #1;
        btn_n = 1'b1;
        rstn  = 1'b0;
        #1;
        check("async_led", 32'(led), 32'd0);
        check("async_mode", 32'(mode), 32'd0);
        check("async_tick", 32'(tick), 32'd0);
        model_reset();
        #20;
        check("hold_led", 32'(led), 32'd0);
        rstn = 1'b1;
        wait_tick(1'b1, gap);
        check("post_reset_gap", 32'(gap), 32'(TD));
        check("post_reset_led", 32'(led), 32'd1);
        wait_tick(1'b1, gap);
        check("post_reset_led2", 32'(led), 32'd2);
        @(negedge clk1);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
